// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one main-memory block port between the I- and D-cache.
// Optional macro CACHE_ARB_WB_PRIO_EN: a lone writeback beats a refill in IDLE.
module cache_mem_arbiter #(
    parameter int PA_WIDTH  = 32,
    parameter int MEM_WIDTH = 512,
    parameter int BO_WIDTH  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_we,
    input  logic [2*PA_WIDTH-1:0]  req_addr,
    input  logic [2*MEM_WIDTH-1:0] req_wdata,
    output logic [1:0]             req_ready,
    output logic [1:0]             rsp_valid,
    output logic [MEM_WIDTH-1:0]   rsp_rdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [PA_WIDTH-1:0]    mem_addr,
    output logic [MEM_WIDTH-1:0]   mem_wdata,
    input  logic                   mem_ack,
    input  logic [MEM_WIDTH-1:0]   mem_rdata,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic                   prio_q, prio_d;
    logic                   owner_q, owner_d;
    logic                   we_q, we_d;
    logic [PA_WIDTH-1:0]    addr_q, addr_d;
    logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
    logic [MEM_WIDTH-1:0]   rdata_q, rdata_d;

    logic [1:0]             win;
    logic                   win_idx;
    logic [PA_WIDTH-1:0]    sel_addr;

    always_comb begin
        win = 2'b00;
        case (req_valid)
            2'b01: win = 2'b01;
            2'b10: win = 2'b10;
            2'b11: begin
`ifdef CACHE_ARB_WB_PRIO_EN
                // A lone writeback goes first so a dirty victim leaves before its set is refilled.
                if (req_we[0] ^ req_we[1]) begin
                    win = req_we[1] ? 2'b10 : 2'b01;
                end else begin
                    win = prio_q ? 2'b10 : 2'b01;
                end
`else
                win = prio_q ? 2'b10 : 2'b01;
`endif
            end
            default: win = 2'b00;
        endcase
    end

    assign win_idx  = win[1];
    assign sel_addr = win_idx ? req_addr[PA_WIDTH +: PA_WIDTH] : req_addr[0 +: PA_WIDTH];

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (!rst) begin
                    req_ready = win;
                end
                if (|req_ready) begin
                    owner_d = win_idx;
                    we_d    = req_we[win_idx];
                    addr_d  = {sel_addr[PA_WIDTH-1:BO_WIDTH], {BO_WIDTH{1'b0}}};
                    wdata_d = win_idx ? req_wdata[MEM_WIDTH +: MEM_WIDTH]
                                      : req_wdata[0 +: MEM_WIDTH];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                prio_d    = ~owner_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_req   = (state_q == S_ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cache_mem_arbiter;

    localparam int PA = 32;
    localparam int MW = 512;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_we = '0;
    logic [2*PA-1:0] req_addr = '0;
    logic [2*MW-1:0] req_wdata = '0;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [MW-1:0]   rsp_rdata;
    logic            mem_req;
    logic            mem_we;
    logic [PA-1:0]   mem_addr;
    logic [MW-1:0]   mem_wdata;
    logic            mem_ack = 1'b0;
    logic [MW-1:0]   mem_rdata = '0;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int grants[$];

    cache_mem_arbiter #(.PA_WIDTH(PA), .MEM_WIDTH(MW), .BO_WIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Winner chosen by the arbitration rules; -1 when nobody asks.
    function automatic int pick(input logic [1:0] v, input logic [1:0] we, input logic p);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef CACHE_ARB_WB_PRIO_EN
        if (we == 2'b01) return 0;
        if (we == 2'b10) return 1;
`else
        if (we == 2'b11) return int'(p);
`endif
        return int'(p);
    endfunction

    // Reference model: one open transaction at a time, then a response cycle.
    logic          m_open = 1'b0, m_due = 1'b0, m_prio = 1'b0, m_owner = 1'b0, m_we = 1'b0;
    logic [PA-1:0] m_addr = '0;
    logic [MW-1:0] m_wdata = '0, m_rdata = '0;

    always @(negedge clk) begin
        int w;
        logic [1:0] er;
        if (rst) begin
            m_open = 0; m_due = 0; m_prio = 0; m_owner = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
        end
        w  = pick(req_valid, req_we, m_prio);
        er = (!rst && !m_open && !m_due && w >= 0) ? (2'b01 << w) : 2'b00;
        chk("m_req_ready", 512'(req_ready), 512'(er));
        chk("m_mem_req", 512'(mem_req), 512'(m_open));
        chk("m_busy", 512'(busy), 512'(m_open | m_due));
        chk("m_rsp_valid", 512'(rsp_valid), 512'(m_due ? (2'b01 << m_owner) : 2'b00));
        chk("m_rsp_rdata", rsp_rdata, m_rdata);
        if (m_open || rst) begin
            chk("m_mem_we", 512'(mem_we), 512'(m_we));
            chk("m_mem_addr", 512'(mem_addr), 512'({m_addr[PA-1:6], 6'b0}));
            chk("m_mem_wdata", mem_wdata, m_wdata);
        end
        if (!rst) begin
            if (m_due) begin
                m_due  = 0;
                m_prio = ~m_owner;
            end else if (m_open) begin
                if (mem_ack) begin
                    m_open = 0;
                    m_due  = 1;
                    if (!m_we) m_rdata = mem_rdata;
                end
            end else if (w >= 0) begin
                m_open  = 1;
                m_owner = w[0];
                m_we    = req_we[w];
                m_addr  = req_addr[w*PA +: PA];
                m_wdata = req_wdata[w*MW +: MW];
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    // Run until all requests are served; accepted ports drop valid, memory acks after `delay`.
    task automatic serve(input int delay, input int maxc);
        int dcnt;
        int n;
        logic [1:0] acc;
        dcnt = delay;
        n = 0;
        grants.delete();
        while (n < maxc) begin
            smp();
            acc = req_valid & req_ready;
            if (acc == 2'b01) grants.push_back(0);
            if (acc == 2'b10) grants.push_back(1);
            if (req_valid == 2'b00 && !busy) break;
            nxt();
            req_valid = req_valid & ~acc;
            if (mem_ack) mem_ack = 1'b0;
            else if (mem_req) begin
                if (dcnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = rnd_blk();
                    dcnt = delay;
                end else dcnt--;
            end
            n++;
        end
        chk("serve_timeout", 512'(n >= maxc), 512'(0));
    endtask

    task automatic chk_grants(input string name, input int g0, input int g1);
        chk({name, "_count"}, 512'(grants.size()), 512'(2));
        chk({name, "_first"}, 512'(grants.size() > 0 ? grants[0] : 9), 512'(g0));
        chk({name, "_second"}, 512'(grants.size() > 1 ? grants[1] : 9), 512'(g1));
    endtask

    initial begin
        logic [511:0] prev;
        logic [511:0] pat;
        logic [1:0]   acc;
        int           dcnt;

        // Reset values, with requests present to show req_ready is held low.
        req_valid = 2'b11;
        smp();
        chk("rst_ready", 512'(req_ready), 512'(0));
        chk("rst_mem_req", 512'(mem_req), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
        chk("rst_rsp_rdata", rsp_rdata, 512'(0));
        chk("rst_mem_addr", 512'(mem_addr), 512'(0));
        chk("rst_mem_we", 512'(mem_we), 512'(0));
        chk("rst_mem_wdata", mem_wdata, 512'(0));
        nxt();
        req_valid = 2'b00;
        rst = 1'b0;

        // Single refill, ack at T1.
        nxt();
        req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h0000_1234;
        smp();
        chk("t1_ready", 512'(req_ready), 512'(2'b01));
        nxt();
        req_valid = 2'b00;
        mem_ack = 1'b1;
        mem_rdata = {64{8'hA5}};
        smp();
        chk("t1_mem_req", 512'(mem_req), 512'(1));
        chk("t1_mem_addr", 512'(mem_addr), 512'(32'h0000_1200));
        nxt();
        mem_ack = 1'b0;
        smp();
        chk("t1_rsp_valid", 512'(rsp_valid), 512'(2'b01));
        chk("t1_rsp_rdata", rsp_rdata, {64{8'hA5}});
        nxt();
        smp();
        chk("t1_busy_t3", 512'(busy), 512'(0));

        // Contention right after reset: port 0 then port 1, twice.
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0;
        nxt();
        req_valid = 2'b11; req_we = 2'b00;
        req_addr = {32'h0000_2000, 32'h0000_3000};
        serve(0, 30);
        chk_grants("t2a", 0, 1);
        nxt();
        req_valid = 2'b11;
        serve(2, 40);
        chk_grants("t2b", 0, 1);

        // Writeback from port 1 with a 5-cycle ack delay.
        prev = rsp_rdata;
        pat = {16{32'hDEAD_BEEF}};
        nxt();
        req_valid = 2'b10; req_we = 2'b10;
        req_addr[63:32] = 32'h8000_0040;
        req_wdata[1023:512] = pat;
        smp();
        chk("t3_ready", 512'(req_ready), 512'(2'b10));
        nxt();
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("t3_mem_req", 512'(mem_req), 512'(1));
            chk("t3_mem_we", 512'(mem_we), 512'(1));
            chk("t3_mem_addr", 512'(mem_addr), 512'(32'h8000_0040));
            chk("t3_mem_wdata", mem_wdata, pat);
            nxt();
        end
        mem_ack = 1'b1;
        mem_rdata = rnd_blk();
        smp();
        chk("t3_mem_req_ack", 512'(mem_req), 512'(1));
        nxt();
        mem_ack = 1'b0;
        smp();
        chk("t3_rsp_valid", 512'(rsp_valid), 512'(2'b10));
        chk("t3_rsp_rdata", rsp_rdata, prev);
        nxt();
        smp();
        chk("t3_rsp_single", 512'(rsp_valid), 512'(0));
        chk("t3_busy", 512'(busy), 512'(0));

        // prio is 0: refill on port 0 against writeback on port 1.
        nxt();
        req_valid = 2'b11; req_we = 2'b10;
        serve(1, 40);
`ifdef CACHE_ARB_WB_PRIO_EN
        chk_grants("t4", 1, 0);
`else
        chk_grants("t4", 0, 1);
`endif

        // Reset during a waiting ISSUE after pushing prio to 1.
        nxt();
        req_valid = 2'b01; req_we = 2'b00;
        serve(0, 20);
        nxt();
        req_valid = 2'b01;
        smp();
        chk("t5_ready", 512'(req_ready), 512'(2'b01));
        nxt();
        req_valid = 2'b00;
        nxt();
        nxt();
        rst = 1'b1;
        #1;
        chk("t5_mem_req_async", 512'(mem_req), 512'(0));
        chk("t5_busy_async", 512'(busy), 512'(0));
        smp();
        chk("t5_rsp_valid", 512'(rsp_valid), 512'(0));
        nxt();
        rst = 1'b0;
        smp();
        chk("t5_busy_after", 512'(busy), 512'(0));
        chk("t5_rsp_after", 512'(rsp_valid), 512'(0));
        nxt();
        req_valid = 2'b11;
        serve(0, 30);
        chk_grants("t5_prio", 0, 1);

        // Spurious ack in IDLE.
        prev = rsp_rdata;
        nxt();
        mem_ack = 1'b1;
        mem_rdata = rnd_blk();
        smp();
        chk("t6_busy", 512'(busy), 512'(0));
        chk("t6_mem_req", 512'(mem_req), 512'(0));
        nxt();
        mem_rdata = rnd_blk();
        smp();
        chk("t6_rsp_valid", 512'(rsp_valid), 512'(0));
        nxt();
        mem_ack = 1'b0;
        smp();
        chk("t6_busy_after", 512'(busy), 512'(0));
        chk("t6_rsp_rdata", rsp_rdata, prev);

        // Randomized traffic with random ack delays, spurious acks and rare resets.
        dcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            smp();
            acc = req_valid & req_ready;
            nxt();
            rst = !rst && ($urandom_range(0, 399) == 0);
            req_valid = req_valid & ~acc;
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] && $urandom_range(0, 2) == 0) begin
                    req_valid[p] = 1'b1;
                    req_we[p] = 1'($urandom);
                    req_addr[p*PA +: PA] = $urandom;
                    req_wdata[p*MW +: MW] = rnd_blk();
                end
            end
            if (rst || mem_ack) begin
                mem_ack = 1'b0;
                dcnt = $urandom_range(0, 5);
            end else if (mem_req) begin
                if (dcnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = rnd_blk();
                end else dcnt--;
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack = 1'b1;
                mem_rdata = rnd_blk();
            end
        end
        smp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-port arbiter and sequencer that shares the single main-memory block port between two cache controllers (instruction and data). It accepts block refill (read) and dirty-block writeback (write) requests and serialises them with round-robin fairness. It drives the memory request/acknowledge handshake and returns completion and refill data to the owning requester. It sits between the cache controllers' `mem_*` outputs and the memory model.

## Interface
- `PA_WIDTH`, 32, physical address width
- `MEM_WIDTH`, 512, block width in bits (64 B block)
- `BO_WIDTH`, 6, block-offset bits forced to zero on `mem_addr`

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `req_valid`  in  2  per-port request; held until accepted
- `req_we`  in  2  per-port: 1 = writeback, 0 = refill
- `req_addr`  in  2*PA_WIDTH  port p occupies bits [p*PA_WIDTH +: PA_WIDTH]
- `req_wdata`  in  2*MEM_WIDTH  writeback block, same packing as `req_addr`
- `req_ready`  out  2  combinational accept, one-hot or zero
- `rsp_valid`  out  2  one-cycle completion pulse to the owning port
- `rsp_rdata`  out  MEM_WIDTH  refill block, valid while `rsp_valid` is set
- `mem_req`  out  1  memory request, held until acknowledged
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  PA_WIDTH  block-aligned address
- `mem_wdata`  out  MEM_WIDTH  block to write
- `mem_ack`  in  1  memory completion; `mem_rdata` valid in the same cycle
- `mem_rdata`  in  MEM_WIDTH  block read from memory
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- FSM states:
  - IDLE: `req_ready[g]` is high for the winner `g`, combinationally. On the edge where `req_valid[g] & req_ready[g]`, capture `req_we`, `req_addr` and `req_wdata` of `g` into registers, set `owner=g`, and go to ISSUE.
  - ISSUE: `mem_req=1`, with `mem_we/mem_addr/mem_wdata` driven from the captured registers and stable. When `mem_ack` is sampled high, latch `mem_rdata` into `rsp_rdata` (refill only; on a writeback `rsp_rdata` holds its previous value) and go to RESP.
  - RESP: `rsp_valid[owner]=1` for exactly one cycle. Toggle the round-robin pointer `prio` to `~owner`, then go to IDLE.
- Arbitration:
  - If only one port is valid, that port wins.
  - If both ports are valid, port `prio` wins.
  - Ties are resolved only in IDLE; a request arriving during ISSUE or RESP waits.
- `mem_addr` = captured address with bits [BO_WIDTH-1:0] forced to 0.
- `mem_ack` is ignored outside ISSUE.
- A request whose `req_valid` is withdrawn before acceptance is dropped with no side effect; requesters must not do this.

## Timing
- Reset values:
  - State IDLE, `prio=0`, `owner=0`.
  - Outputs `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `busy=0`.
  - While `rst` is asserted, `req_ready` is forced to 0.
- Reset mid-transaction: `mem_req` drops asynchronously. The transaction is abandoned with no `rsp_valid`.
- Cycle-level sequence:
  - Accept in cycle T0.
  - `mem_req` is high from T1.
  - The earliest `mem_ack` is at T1; with it, `rsp_valid` is high in T2 and `req_ready` can go high again in T3.
  - The minimum transaction is 3 cycles; throughput is one transaction per 3 + (ack wait) cycles.
- `mem_req` never deasserts in ISSUE before `mem_ack`. Exactly one memory transaction is issued per accepted request.
- `req_ready` and `rsp_valid` are never both high in the same cycle.

## Configuration
- `CACHE_ARB_WB_PRIO_EN`:
  - Defined: in IDLE, if exactly one valid port has `req_we=1`, that port wins regardless of `prio`. This ensures a dirty victim is flushed before a refill overwrites its set. If both or neither are writebacks, round-robin applies. `prio` still toggles after every transaction.
  - Undefined: pure round-robin as above.

## Test plan
- Single refill: port 0, addr 0x0000_1234, `req_we=0`; memory acks at T1 with `mem_rdata`=0xA5 pattern. Required: `mem_addr`=0x0000_1200, `rsp_valid`=2'b01 at T2, `rsp_rdata`=0xA5 pattern, `busy` is 0 at T3.
- Contention after reset: both ports request refills in the same cycle. Required: port 0 is granted first, then port 1. A second simultaneous pair from both ports is granted port 0, then port 1 again, since `prio` alternates after each transaction.
- Writeback with a 5-cycle ack delay: port 1 issues a write at addr 0x8000_0040 with `wdata` = 0xDEAD… pattern. Required: `mem_req=1`, `mem_we=1`, and stable addr/data for all 5 cycles. Exactly one `rsp_valid[1]` pulse. `rsp_rdata` is unchanged.
- Priority option: `prio=0`, port 0 refill and port 1 writeback requested together. Required: with `CACHE_ARB_WB_PRIO_EN` defined, port 1 is served first; without it, port 0 is served first.
- Reset mid-ISSUE: assert `rst` two cycles into a waiting transaction. Required: `mem_req` is 0 immediately, no `rsp_valid` pulse, and after release `prio=0` and `busy=0`.
- Spurious `mem_ack` while in IDLE with no requests. Required: no state change and no `rsp_valid`.
